// File: rtl/tile_pixel_fetch.sv
// tile_pixel_fetch: three-stage pixel fetch for the tile video path.
// Stage 0 turns the pixel position into a tile map / colour address.
// Stage 1 turns the returned tile index into a bitmap ROM row address.
// Stage 2 selects the pixel bit and forms the palette lookup index.
// hsync/vsync ride a matching 3-deep delay line.
// Optional feature: define TILE_SCROLL_EN to add scroll_x/scroll_y inputs that
// offset the fetched coordinates (wrapping at the screen size).
module tile_pixel_fetch #(
  parameter int unsigned MAP_COLS = 80,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 400
) (
  input  logic        clk,
  input  logic        reset,
`ifdef TILE_SCROLL_EN
  input  logic [9:0]  scroll_x,
  input  logic [9:0]  scroll_y,
`endif
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        active_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        map_ren,
  output logic [11:0] map_raddr,
  input  logic [7:0]  map_rdata,
  output logic        col_ren,
  output logic [11:0] col_raddr,
  input  logic [3:0]  col_rdata,
  output logic        bmp_ren,
  output logic [11:0] bmp_raddr,
  input  logic [7:0]  bmp_rdata,
  output logic [4:0]  pal_idx,
  output logic        pixel_valid,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [10:0] W_LIM = 11'(SCREEN_W);
  localparam logic [10:0] H_LIM = 11'(SCREEN_H);

  logic [9:0]  w_ex;
  logic [9:0]  w_ey;
  logic        w_inb;
  logic [6:0]  w_tileCol;
  logic [5:0]  w_tileRow;
  logic [3:0]  w_subRow;
  logic [2:0]  w_subCol;
  logic [11:0] w_rowBase;
  logic [11:0] w_addr;
  logic [2:0]  w_bitSel;

  logic        r_mapRen;
  logic [11:0] r_rdAddr;
  logic        r_inbD1;
  logic [3:0]  r_subRowD1;
  logic [2:0]  r_subColD1;

  logic        r_bmpRen;
  logic [11:0] r_bmpRaddr;
  logic [3:0]  r_paletteD2;
  logic [2:0]  r_subColD2;
  logic        r_inbD2;

  logic [4:0]  r_palIdx;
  logic        r_pixelValid;
  logic [2:0]  r_hsPipe;
  logic [2:0]  r_vsPipe;

`ifdef TILE_SCROLL_EN
  // Scrolled coordinates: one add and one conditional subtract wrap into the screen.
  logic [10:0] w_exSum;
  logic [10:0] w_eySum;
  assign w_exSum = {1'b0, x} + {1'b0, scroll_x};
  assign w_eySum = {1'b0, y} + {1'b0, scroll_y};
  assign w_ex = (w_exSum >= W_LIM) ? 10'(w_exSum - W_LIM) : w_exSum[9:0];
  assign w_ey = (w_eySum >= H_LIM) ? 10'(w_eySum - H_LIM) : w_eySum[9:0];
`else
  assign w_ex = x;
  assign w_ey = y;
`endif

  // Visibility always follows the raw timing position, never the scrolled one.
  assign w_inb = active_in && ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);

  assign w_tileCol = w_ex[9:3];
  assign w_tileRow = w_ey[9:4];
  assign w_subRow  = w_ey[3:0];
  assign w_subCol  = w_ex[2:0];

  // Row stride of 80 is built from two shifted copies so no multiplier appears.
  if (MAP_COLS == 80) begin : g_stride80
    assign w_rowBase = ({6'b0, w_tileRow} << 6) + ({6'b0, w_tileRow} << 4);
  end else begin : g_strideGeneric
    assign w_rowBase = 12'(w_tileRow * MAP_COLS);
  end

  assign w_addr = w_rowBase + {5'b0, w_tileCol};

  // Stage 1 registers: issue map/colour reads; the address holds across blank pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mapRen   <= 1'b0;
      r_rdAddr   <= '0;
      r_inbD1    <= 1'b0;
      r_subRowD1 <= '0;
      r_subColD1 <= '0;
    end else begin
      r_mapRen   <= w_inb;
      if (w_inb) begin
        r_rdAddr <= w_addr;
      end
      r_inbD1    <= w_inb;
      r_subRowD1 <= w_subRow;
      r_subColD1 <= w_subCol;
    end
  end

  // Stage 2 registers: issue the bitmap row read and carry the palette number alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bmpRen    <= 1'b0;
      r_bmpRaddr  <= '0;
      r_paletteD2 <= '0;
      r_subColD2  <= '0;
      r_inbD2     <= 1'b0;
    end else begin
      r_bmpRen    <= r_inbD1;
      if (r_inbD1) begin
        r_bmpRaddr <= {map_rdata, r_subRowD1};
      end
      r_paletteD2 <= col_rdata;
      r_subColD2  <= r_subColD1;
      r_inbD2     <= r_inbD1;
    end
  end

  // Bit 7 of a bitmap row is the leftmost pixel, so column c selects bit 7-c.
  assign w_bitSel = ~r_subColD2;

  // Output stage: blank pixels are forced to palette index zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_palIdx     <= '0;
      r_pixelValid <= 1'b0;
    end else begin
      r_pixelValid <= r_inbD2;
      r_palIdx     <= r_inbD2 ? {r_paletteD2, bmp_rdata[w_bitSel]} : 5'd0;
    end
  end

  // Sync delay lines matched to the three pixel stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsPipe <= '0;
      r_vsPipe <= '0;
    end else begin
      r_hsPipe <= {r_hsPipe[1:0], hsync_in};
      r_vsPipe <= {r_vsPipe[1:0], vsync_in};
    end
  end

  assign map_ren     = r_mapRen;
  assign col_ren     = r_mapRen;
  assign map_raddr   = r_rdAddr;
  assign col_raddr   = r_rdAddr;
  assign bmp_ren     = r_bmpRen;
  assign bmp_raddr   = r_bmpRaddr;
  assign pal_idx     = r_palIdx;
  assign pixel_valid = r_pixelValid;
  assign hsync_out   = r_hsPipe[2];
  assign vsync_out   = r_vsPipe[2];

endmodule
